// File: rtl/plic_lite.sv
// plic_lite: NUM_SRC-source prioritised interrupt controller with claim/complete
// gateways, a register slave on the execute-stage bus and one registered request
// line toward the core.
// Optional feature macro: PLIC_LITE_EDGE_EN adds the EDGE register and the
// rising-edge trigger path. Without it every source is level-triggered.
module plic_lite #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  int_src_i,
  input  logic                reg_req_i,
  input  logic                reg_we_i,
  input  logic [7:0]          reg_addr_i,
  input  logic [31:0]         reg_wdata_i,
  output logic [31:0]         reg_rdata_o,
  output logic                ext_int_o
);

  localparam int unsigned ID_W = 5;

  localparam logic [5:0] W_PENDING = 6'h00;
  localparam logic [5:0] W_ENABLE  = 6'h01;
  localparam logic [5:0] W_EDGE    = 6'h02;
  localparam logic [5:0] W_THRESH  = 6'h03;
  localparam logic [5:0] W_CLAIM   = 6'h04;
  localparam logic [5:0] W_PRIO0   = 6'h20;

  logic [NUM_SRC-1:0]             sync1_q, sync1_d;
  logic [NUM_SRC-1:0]             sync2_q, sync2_d;
  logic [NUM_SRC-1:0]             pending_q, pending_d;
  logic [NUM_SRC-1:0]             inservice_q, inservice_d;
  logic [NUM_SRC-1:0]             enable_q, enable_d;
  logic [PRIO_W-1:0]              threshold_q, threshold_d;
  logic [NUM_SRC-1:0][PRIO_W-1:0] prio_q, prio_d;
  logic [ID_W-1:0]                best_id_q, best_id_d;
  logic                           ext_int_q, ext_int_d;

  logic [5:0]         word_c;
  logic               wr_en_c;
  logic               rd_en_c;
  logic               claim_c;
  logic               complete_c;
  logic [ID_W-1:0]    cmp_id_c;
  logic [NUM_SRC-1:0] set_c;
  logic [PRIO_W-1:0]  best_prio_c;

  logic unused_bits;
  assign unused_bits = ^{reg_addr_i[1:0], reg_wdata_i};

  // Bus decode: word index, claim and complete strobes
  always_comb begin
    word_c     = reg_addr_i[7:2];
    wr_en_c    = reg_req_i & reg_we_i;
    rd_en_c    = reg_req_i & ~reg_we_i;
    cmp_id_c   = reg_wdata_i[ID_W-1:0];
    claim_c    = rd_en_c && (word_c == W_CLAIM) && (best_id_q != '0);
    complete_c = wr_en_c && (word_c == W_CLAIM) && (cmp_id_c != '0) &&
                 (32'(cmp_id_c) <= NUM_SRC);
  end

`ifdef PLIC_LITE_EDGE_EN
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] sync3_q, sync3_d;

  // Edge gateway: rising edges latch even while in service, level needs idle
  always_comb begin
    sync3_d = sync2_q;
    edge_d  = edge_q;
    if (wr_en_c && (word_c == W_EDGE)) edge_d = reg_wdata_i[NUM_SRC-1:0];
    set_c = (edge_q & sync2_q & ~sync3_q) | (~edge_q & sync2_q & ~inservice_q);
  end

  // Edge-detector and EDGE register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync3_q <= '0;
      edge_q  <= '0;
    end else begin
      sync3_q <= sync3_d;
      edge_q  <= edge_d;
    end
  end
`else
  // Level-only gateway
  always_comb begin
    set_c = sync2_q & ~inservice_q;
  end
`endif

  // Synchroniser, gateway state and RW register next-state
  always_comb begin
    sync1_d     = int_src_i;
    sync2_d     = sync1_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    prio_d      = prio_q;
    pending_d   = pending_q | set_c;
    inservice_d = inservice_q;

    if (wr_en_c) begin
      case (word_c)
        W_ENABLE: enable_d    = reg_wdata_i[NUM_SRC-1:0];
        W_THRESH: threshold_d = reg_wdata_i[PRIO_W-1:0];
        default: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (word_c == (W_PRIO0 + 6'(i))) prio_d[i] = reg_wdata_i[PRIO_W-1:0];
          end
        end
      endcase
    end

    // Claim wins over a same-cycle set on the claimed source
    for (int i = 0; i < NUM_SRC; i++) begin
      if (claim_c && (best_id_q == ID_W'(i + 1))) begin
        pending_d[i]   = 1'b0;
        inservice_d[i] = 1'b1;
      end
      if (complete_c && (cmp_id_c == ID_W'(i + 1))) begin
        inservice_d[i] = 1'b0;
      end
    end
  end

  // Arbiter: highest priority above threshold, lowest index on ties
  always_comb begin
    best_prio_c = threshold_q;
    best_id_d   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (pending_q[i] && enable_q[i] && !inservice_q[i] && (prio_q[i] > best_prio_c)) begin
        best_prio_c = prio_q[i];
        best_id_d   = ID_W'(i + 1);
      end
    end
    ext_int_d = (best_id_d != '0);
  end

  // Read mux, combinational from the address
  always_comb begin
    reg_rdata_o = '0;
    case (word_c)
      W_PENDING: reg_rdata_o = 32'(pending_q);
      W_ENABLE:  reg_rdata_o = 32'(enable_q);
`ifdef PLIC_LITE_EDGE_EN
      W_EDGE:    reg_rdata_o = 32'(edge_q);
`endif
      W_THRESH:  reg_rdata_o = 32'(threshold_q);
      W_CLAIM:   reg_rdata_o = 32'(best_id_q);
      default: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (word_c == (W_PRIO0 + 6'(i))) reg_rdata_o = 32'(prio_q[i]);
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      pending_q   <= '0;
      inservice_q <= '0;
      enable_q    <= '0;
      threshold_q <= '0;
      prio_q      <= '0;
      best_id_q   <= '0;
      ext_int_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      pending_q   <= pending_d;
      inservice_q <= inservice_d;
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      prio_q      <= prio_d;
      best_id_q   <= best_id_d;
      ext_int_q   <= ext_int_d;
    end
  end

  assign ext_int_o = ext_int_q;

endmodule
